ram_arbiter_fsm: RTL and testbench

// - Sequences the single-port RAM on behalf of instruction fetch and data access.
// - Arbitrates imem/dmem requests and latches the winner's address and store data.
// - Holds Ren/Wen until the RAM drops ram_busy, then returns load data with a one-cycle ready pulse.
// - Sits between the core (fetch/LSU) and the RAM model; supersedes direct combinational muxing.

---
 rtl/ram_arbiter_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_ram_arbiter_fsm.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_fsm.sv
// Single-port RAM sequencer arbitrating instruction fetch and data access (IDLE -> ACCESS -> RESP).
// Optional fetch-fairness streak limiter is enabled by defining FETCH_FAIR_EN.
module ram_arbiter_fsm #(
    parameter int TIMEOUT     = 16,
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemRen,
    input  logic [31:0] imemaddr,
    input  logic        dmmRen,
    input  logic        dmmWen,
    input  logic [31:0] dmmaddr,
    input  logic [31:0] dmmstore,
    input  logic        ram_busy,
    input  logic [31:0] ramload,
    output logic        Ren,
    output logic        Wen,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        i_ready,
    output logic        d_ready,
    output logic [31:0] imemload,
    output logic [31:0] dmmload,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("ram_arbiter_fsm: TIMEOUT must be at least 2");
        end
        if (MAX_DSTREAK < 1) begin : g_bad_max_dstreak
            $error("ram_arbiter_fsm: MAX_DSTREAK must be at least 1");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [31:0]        addr_reg, addr_next;
    logic [31:0]        store_reg, store_next;
    logic               sel_d_reg, sel_d_next;
    logic               op_wr_reg, op_wr_next;
    logic               err_reg, err_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic [31:0]        iload_reg, iload_next;
    logic [31:0]        dload_reg, dload_next;

    logic data_req;
    logic grant_data;

    assign data_req = dmmRen | dmmWen;

`ifdef FETCH_FAIR_EN
    localparam int                  DS_W   = $clog2(MAX_DSTREAK + 1);
    localparam logic [DS_W-1:0]     DS_MAX = DS_W'(MAX_DSTREAK);

    logic [DS_W-1:0] dstreak_reg, dstreak_next;
    logic            force_fetch;

    // A starved fetch wins once the data streak has saturated.
    assign force_fetch = imemRen && (dstreak_reg == DS_MAX);
    assign grant_data  = data_req && !force_fetch;

    always_comb begin
        dstreak_next = dstreak_reg;
        if (state_reg == IDLE) begin
            if (grant_data) begin
                if (imemRen && (dstreak_reg != DS_MAX)) begin
                    dstreak_next = dstreak_reg + DS_W'(1);
                end
            end else if (imemRen) begin
                dstreak_next = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak_reg <= '0;
        end else begin
            dstreak_reg <= dstreak_next;
        end
    end
`else
    assign grant_data = data_req;
`endif

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        store_next  = store_reg;
        sel_d_next  = sel_d_reg;
        op_wr_next  = op_wr_reg;
        err_next    = err_reg;
        wait_next   = wait_reg;
        iload_next  = iload_reg;
        dload_next  = dload_reg;
        Ren         = 1'b0;
        Wen         = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        timeout_err = 1'b0;

        case (state_reg)
            IDLE: begin
                wait_next = '0;
                err_next  = 1'b0;
                if (grant_data) begin
                    addr_next  = dmmaddr;
                    store_next = dmmstore;
                    sel_d_next = 1'b1;
                    // Read and write together are serviced as a write.
                    op_wr_next = dmmWen;
                    state_next = ACCESS;
                end else if (imemRen) begin
                    addr_next  = imemaddr;
                    sel_d_next = 1'b0;
                    op_wr_next = 1'b0;
                    state_next = ACCESS;
                end
            end

            ACCESS: begin
                Ren = !op_wr_reg;
                Wen = op_wr_reg;
                if (!ram_busy) begin
                    if (!op_wr_reg) begin
                        if (sel_d_reg) begin
                            dload_next = ramload;
                        end else begin
                            iload_next = ramload;
                        end
                    end
                    state_next = RESP;
                end else if (wait_reg == WAIT_LAST) begin
                    // Abandoned reads return zero so stale data is never mistaken for a result.
                    err_next = 1'b1;
                    if (!op_wr_reg) begin
                        if (sel_d_reg) begin
                            dload_next = 32'h0;
                        end else begin
                            iload_next = 32'h0;
                        end
                    end
                    state_next = RESP;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end

            RESP: begin
                i_ready     = !sel_d_reg;
                d_ready     = sel_d_reg;
                timeout_err = err_reg;
                wait_next   = '0;
                state_next  = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            store_reg <= '0;
            sel_d_reg <= 1'b0;
            op_wr_reg <= 1'b0;
            err_reg   <= 1'b0;
            wait_reg  <= '0;
            iload_reg <= '0;
            dload_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            store_reg <= store_next;
            sel_d_reg <= sel_d_next;
            op_wr_reg <= op_wr_next;
            err_reg   <= err_next;
            wait_reg  <= wait_next;
            iload_reg <= iload_next;
            dload_reg <= dload_next;
        end
    end

    assign ramaddr  = addr_reg;
    assign ramstore = store_reg;
    assign imemload = iload_reg;
    assign dmmload  = dload_reg;

endmodule

// File: tb/tb_ram_arbiter_fsm.sv
// Self-checking bench for ram_arbiter_fsm: directed corner cases then random traffic
// checked against a transaction-level model of pending requests and returned loads.
module tb_ram_arbiter_fsm;

    localparam int TIMEOUT     = 16;
    localparam int MAX_DSTREAK = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        imemRen = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        dmmRen = 1'b0;
    logic        dmmWen = 1'b0;
    logic [31:0] dmmaddr = '0;
    logic [31:0] dmmstore = '0;
    logic        ram_busy = 1'b0;
    logic [31:0] ramload = '0;
    logic        Ren, Wen, i_ready, d_ready, timeout_err;
    logic [31:0] ramaddr, ramstore, imemload, dmmload;

    ram_arbiter_fsm #(.TIMEOUT(TIMEOUT), .MAX_DSTREAK(MAX_DSTREAK)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemRen(imemRen), .imemaddr(imemaddr),
        .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
        .ram_busy(ram_busy), .ramload(ramload),
        .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore),
        .i_ready(i_ready), .d_ready(d_ready),
        .imemload(imemload), .dmmload(dmmload), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: what each requester is asking for, and what the core should see as loaded data.
    bit          i_pend = 0, d_pend = 0, d_rd = 0, d_wr = 0;
    logic [31:0] i_addr = '0, d_addr = '0, d_store = '0;
    logic [31:0] m_iload = '0, m_dload = '0;
    int          m_streak = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_req();
        imemRen  = i_pend;
        imemaddr = i_addr;
        dmmRen   = d_pend && d_rd;
        dmmWen   = d_pend && d_wr;
        dmmaddr  = d_addr;
        dmmstore = d_store;
    endtask

    // Called just after an edge that left the DUT in IDLE; runs one complete access.
    task automatic do_txn(input int busy, input logic [31:0] load_val);
        bit          grant_d, is_wr, err;
        int          n_acc;
        logic [31:0] exp_addr, rd_val;
        drive_req();
        ram_busy = 1'b0;
        chk("idle_strobes", {28'd0, Ren, Wen, i_ready, d_ready}, 32'd0);
        grant_d = d_pend;
`ifdef FETCH_FAIR_EN
        if (i_pend && m_streak == MAX_DSTREAK) grant_d = 0;
        if (grant_d && i_pend && m_streak < MAX_DSTREAK) m_streak++;
        if (!grant_d && i_pend) m_streak = 0;
`endif
        if (!grant_d && !i_pend) begin
            tick();
            chk("idle_stays", {30'd0, Ren, Wen}, 32'd0);
        end else begin
            is_wr    = grant_d && d_wr;
            exp_addr = grant_d ? d_addr : i_addr;
            err      = (busy >= TIMEOUT);
            n_acc    = err ? TIMEOUT : busy + 1;
            tick();
            for (int k = 1; k <= n_acc; k++) begin
                ram_busy = (k <= busy);
                ramload  = (k <= busy) ? $urandom : load_val;
                if (k == 1) begin
                    imemaddr = $urandom;
                    dmmaddr  = $urandom;
                    dmmstore = $urandom;
                end
                chk("access_ren", {31'd0, Ren}, {31'd0, !is_wr});
                chk("access_wen", {31'd0, Wen}, {31'd0, is_wr});
                chk("access_addr", ramaddr, exp_addr);
                if (is_wr) chk("access_store", ramstore, d_store);
                tick();
            end
            ram_busy = 1'b0;
            ramload  = $urandom;
            if (!is_wr) begin
                rd_val = err ? 32'h0 : load_val;
                if (grant_d) m_dload = rd_val;
                else         m_iload = rd_val;
            end
            chk("resp_strobes", {30'd0, Ren, Wen}, 32'd0);
            chk("resp_i_ready", {31'd0, i_ready}, {31'd0, !grant_d});
            chk("resp_d_ready", {31'd0, d_ready}, {31'd0, grant_d});
            chk("resp_timeout_err", {31'd0, timeout_err}, {31'd0, err});
            chk("resp_imemload", imemload, m_iload);
            chk("resp_dmmload", dmmload, m_dload);
            if (grant_d) d_pend = 0;
            else         i_pend = 0;
            drive_req();
            tick();
            chk("ready_pulse", {29'd0, i_ready, d_ready, timeout_err}, 32'd0);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_strobes", {27'd0, Ren, Wen, i_ready, d_ready, timeout_err}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_loads", imemload | dmmload, 32'd0);
        nRST = 1'b1;

        // Plain fetch, zero wait states
        i_pend = 1; i_addr = 32'h40;
        do_txn(0, 32'h00A00093);

        // Write with three busy cycles
        d_pend = 1; d_rd = 0; d_wr = 1; d_addr = 32'h100; d_store = 32'hCAFEF00D;
        do_txn(3, 32'h11111111);

        // Data beats fetch; fetch follows
        i_pend = 1; i_addr = 32'h44;
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h200;
        do_txn(0, 32'hDEADBEEF);
        do_txn(1, 32'h00B00113);

        // Read+write together is a write
        d_pend = 1; d_rd = 1; d_wr = 1; d_addr = 32'h300; d_store = 32'h5A5A5A5A;
        do_txn(0, 32'h22222222);

        // Busy for TIMEOUT-1 cycles completes; busy stuck aborts
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h304;
        do_txn(TIMEOUT - 1, 32'h33333333);
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h308;
        do_txn(TIMEOUT + 4, 32'h44444444);
        i_pend = 1; i_addr = 32'h48;
        do_txn(TIMEOUT, 32'h55555555);

        // Reset in the middle of an access
        d_pend = 1; d_rd = 1; d_wr = 0; d_addr = 32'h400;
        drive_req();
        ram_busy = 1'b1;
        tick();
        chk("pre_rst_ren", {31'd0, Ren}, 32'd1);
        #2 nRST = 1'b0;
        #1;
        chk("mid_rst_strobes", {28'd0, Ren, Wen, i_ready, d_ready}, 32'd0);
        chk("mid_rst_ramaddr", ramaddr, 32'd0);
        m_iload = '0; m_dload = '0; m_streak = 0;
        tick();
        chk("mid_rst_no_ready", {30'd0, i_ready, d_ready}, 32'd0);
        nRST = 1'b1;
        do_txn(0, 32'h12345678);

        // Random traffic
        for (int n = 0; n < 120; n++) begin
            int op, busy;
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1; i_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                op = $urandom_range(0, 2);
                d_pend = 1; d_rd = (op != 1); d_wr = (op != 0);
                d_addr = $urandom; d_store = $urandom;
            end
            busy = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                               : $urandom_range(0, 3);
            do_txn(busy, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
